// File: rtl/fdam_wr_pkg.sv
// Shared constants, FSM state type and tag helper for the write burst packer.
//   CL_BYTES    : bytes per cache line
//   BURST_LINES : lines per write burst
//   BURST_BYTES : bytes per burst (first address of every burst is aligned to this)
//   t_wr_state  : packer FSM state
//   mk_mdata    : builds the {acc_id, burst index} request tag
package fdam_wr_pkg;
  localparam int CL_BYTES    = 64;
  localparam int BURST_LINES = 4;
  localparam int BURST_BYTES = 256;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} t_wr_state;

  function automatic logic [15:0] mk_mdata(input logic [7:0] acc_id, input logic [7:0] idx);
    return {acc_id, idx};
  endfunction
endpackage

// File: rtl/wr_burst_bank.sv
// One 4-line bank of the ping-pong buffer.
//   clk, rst      : clock, async active-high reset (bank comes up empty)
//   wr_en/wr_data : write one line at the fill pointer (ignored while full)
//   pad           : zero the unwritten slots of a partial bank and mark it full
//   rd_en         : advance the read pointer; after slot 3 the bank is empty
//   full, empty   : bank status
//   rd_ptr        : slot currently presented on rd_data
module wr_burst_bank #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pad,
  input  logic                  rd_en,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            rd_ptr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem_q [4];
  logic [DATA_WIDTH-1:0] mem_d [4];
  logic [1:0] fill_ptr_q, fill_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic       full_q, full_d;

  always_comb begin
    mem_d      = mem_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    full_d     = full_q;
    // writes only happen while not full and reads only while full, so the
    // two branches below never act in the same cycle
    if (wr_en && !full_q) begin
      mem_d[fill_ptr_q] = wr_data;
      fill_ptr_d        = fill_ptr_q + 2'd1;
      full_d            = (fill_ptr_q == 2'd3);
    end else if (pad && !full_q && fill_ptr_q != 2'd0) begin
      for (int i = 0; i < 4; i++)
        if (2'(i) >= fill_ptr_q) mem_d[i] = '0;
      fill_ptr_d = 2'd0;
      full_d     = 1'b1;
    end
    if (rd_en && full_q) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      if (rd_ptr_q == 2'd3) full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_ptr_q <= 2'd0;
      rd_ptr_q   <= 2'd0;
      full_q     <= 1'b0;
    end else begin
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
    end
  end

  // line storage needs no reset: the status flags gate every read
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
  end

  assign full    = full_q;
  assign empty   = !full_q && (fill_ptr_q == 2'd0);
  assign rd_ptr  = rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q];
endmodule

// File: rtl/wr_burst_packer.sv
// Packs an accelerator's output line stream into 4-line, 256B-aligned write
// bursts for the host write channel, and tracks write responses until the
// configured buffer is fully written and acknowledged.
//   clk, rst                      : clock, async active-high reset
//   start                         : run enable (level)
//   conf_valid/addr/num_cl        : configuration strobe, byte base, line count
//   in_valid/in_data/in_ready     : input line stream
//   req_wr_available              : write channel can take a beat
//   req_wr_en/addr/data/mdata     : registered write beats
//   resp_wr_valid/resp_wr_mdata   : write responses, one per burst
//   done                          : all lines written and acknowledged
//   bursts_outstanding            : issued but unacknowledged bursts
module wr_burst_packer
  import fdam_wr_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 48,
  parameter int          DATA_WIDTH  = 512,
  parameter int          MDATA_WIDTH = 16,
  parameter logic [7:0]  ACC_ID      = 8'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   conf_valid,
  input  logic [ADDR_WIDTH-1:0]  conf_addr,
  input  logic [31:0]            conf_num_cl,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  input  logic                   req_wr_available,
  output logic                   req_wr_en,
  output logic [ADDR_WIDTH-1:0]  req_wr_addr,
  output logic [DATA_WIDTH-1:0]  req_wr_data,
  output logic [MDATA_WIDTH-1:0] req_wr_mdata,
  input  logic                   resp_wr_valid,
  input  logic [MDATA_WIDTH-1:0] resp_wr_mdata,
  output logic                   done,
  output logic [7:0]             bursts_outstanding
);
  t_wr_state              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  conf_addr_q, conf_addr_d;
  logic [31:0]            conf_num_q, conf_num_d;
  logic [31:0]            lines_q, lines_d;
  logic [29:0]            burst_idx_q, burst_idx_d;
  logic                   fill_sel_q, fill_sel_d;
  logic                   iss_sel_q, iss_sel_d;
  logic [7:0]             out_q, out_d;
  logic                   done_q, done_d;
  logic                   req_wr_en_q, req_wr_en_d;
  logic [ADDR_WIDTH-1:0]  req_wr_addr_q, req_wr_addr_d;
  logic [DATA_WIDTH-1:0]  req_wr_data_q, req_wr_data_d;
  logic [MDATA_WIDTH-1:0] req_wr_mdata_q, req_wr_mdata_d;

  logic [1:0]                 bank_wr_en, bank_pad, bank_rd_en, bank_full, bank_empty;
  logic [1:0][1:0]            bank_rd_ptr;
  logic [1:0][DATA_WIDTH-1:0] bank_rd_data;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wr_burst_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bank_wr_en[b]),
      .wr_data (in_data),
      .pad     (bank_pad[b]),
      .rd_en   (bank_rd_en[b]),
      .full    (bank_full[b]),
      .empty   (bank_empty[b]),
      .rd_ptr  (bank_rd_ptr[b]),
      .rd_data (bank_rd_data[b])
    );
  end

  logic [32:0] total_bursts;
  logic        lines_left, accept, fire, inc, dec;
  logic [1:0]  iss_ptr;

  assign total_bursts = ({1'b0, conf_num_q} + 33'd3) >> 2;
  assign lines_left   = lines_q < conf_num_q;
  assign in_ready     = (state_q == RUN) && start && !bank_full[fill_sel_q] && lines_left;
  assign accept       = in_valid && in_ready;
  assign iss_ptr      = bank_rd_ptr[iss_sel_q];
  // a burst already underway always finishes; a new one needs RUN, start
  // and headroom in the outstanding counter
  assign fire = req_wr_available && bank_full[iss_sel_q] &&
                (iss_ptr != 2'd0 || (state_q == RUN && start && out_q != 8'hFF));
  assign inc  = fire && (iss_ptr == 2'd0);
  // a stray response with nothing outstanding is dropped rather than wrapping
  assign dec  = resp_wr_valid && (resp_wr_mdata[MDATA_WIDTH-1 -: 8] == ACC_ID) && (out_q != 8'd0);

  always_comb begin
    state_d        = state_q;
    conf_addr_d    = conf_addr_q;
    conf_num_d     = conf_num_q;
    lines_d        = lines_q;
    burst_idx_d    = burst_idx_q;
    fill_sel_d     = fill_sel_q;
    iss_sel_d      = iss_sel_q;
    done_d         = done_q;
    req_wr_en_d    = fire;
    req_wr_addr_d  = req_wr_addr_q;
    req_wr_data_d  = req_wr_data_q;
    req_wr_mdata_d = req_wr_mdata_q;
    bank_wr_en     = '0;
    bank_pad       = '0;
    bank_rd_en     = '0;

    bank_wr_en[fill_sel_q] = accept;
    // once every line is in, flush the partial bank (no-op if already empty/full)
    bank_pad[fill_sel_q]   = (state_q == RUN) && !lines_left;
    bank_rd_en[iss_sel_q]  = fire;
    if (accept) lines_d = lines_q + 32'd1;

    // move filling to the other bank only once it has fully drained, which
    // keeps fill order and issue order identical
    if (bank_full[fill_sel_q] && bank_empty[~fill_sel_q]) fill_sel_d = ~fill_sel_q;

    if (fire) begin
      req_wr_addr_d  = conf_addr_q + ADDR_WIDTH'({burst_idx_q, 8'h00}) + ADDR_WIDTH'({iss_ptr, 6'h00});
      req_wr_data_d  = bank_rd_data[iss_sel_q];
      req_wr_mdata_d = MDATA_WIDTH'(mk_mdata(ACC_ID, burst_idx_q[7:0]));
      if (iss_ptr == 2'd3) begin
        burst_idx_d = burst_idx_q + 30'd1;
        iss_sel_d   = ~iss_sel_q;
      end
    end

    case ({inc, dec})
      2'b10:   out_d = out_q + 8'd1;
      2'b01:   out_d = out_q - 8'd1;
      default: out_d = out_q;
    endcase

    case (state_q)
      IDLE, DONE: begin
        if (conf_valid) begin
          state_d     = IDLE;
          conf_addr_d = conf_addr;
          conf_num_d  = conf_num_cl;
          lines_d     = 32'd0;
          burst_idx_d = 30'd0;
          fill_sel_d  = 1'b0;
          iss_sel_d   = 1'b0;
          done_d      = 1'b0;
        end else if (state_q == IDLE && start) begin
          if (conf_num_q == 32'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN:
        if ({3'b000, burst_idx_q} == total_bursts) state_d = DRAIN;
      DRAIN:
        if (out_q == 8'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      conf_addr_q    <= '0;
      conf_num_q     <= '0;
      lines_q        <= '0;
      burst_idx_q    <= '0;
      fill_sel_q     <= 1'b0;
      iss_sel_q      <= 1'b0;
      out_q          <= '0;
      done_q         <= 1'b0;
      req_wr_en_q    <= 1'b0;
      req_wr_addr_q  <= '0;
      req_wr_data_q  <= '0;
      req_wr_mdata_q <= '0;
    end else begin
      state_q        <= state_d;
      conf_addr_q    <= conf_addr_d;
      conf_num_q     <= conf_num_d;
      lines_q        <= lines_d;
      burst_idx_q    <= burst_idx_d;
      fill_sel_q     <= fill_sel_d;
      iss_sel_q      <= iss_sel_d;
      out_q          <= out_d;
      done_q         <= done_d;
      req_wr_en_q    <= req_wr_en_d;
      req_wr_addr_q  <= req_wr_addr_d;
      req_wr_data_q  <= req_wr_data_d;
      req_wr_mdata_q <= req_wr_mdata_d;
    end
  end

  assign req_wr_en          = req_wr_en_q;
  assign req_wr_addr        = req_wr_addr_q;
  assign req_wr_data        = req_wr_data_q;
  assign req_wr_mdata       = req_wr_mdata_q;
  assign done               = done_q;
  assign bursts_outstanding = out_q;
endmodule
